// File: rtl/qspi_arb.sv
`default_nettype none
// qspi_arb: round-robin scheduler sharing one QSPI controller between I-fill and D-fill/writeback.
// Revision 1.0
module qspi_arb #(
  parameter  int LINE_LENGTH = 4,
  parameter  int PA          = 24,
  parameter  int GAP         = 2,
  localparam int LB          = $clog2(LINE_LENGTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic            i_mem,
  input  logic [PA-LB-1:0] i_addr,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_mem,
  input  logic            d_write,
  input  logic [PA-LB-1:0] d_addr,
  output logic            d_done,
  output logic            q_req,
  output logic            q_i_d,
  output logic            q_mem,
  output logic            q_write,
  output logic [PA-LB-1:0] q_paddr,
  input  logic            q_wstrobe_i,
  input  logic            q_wstrobe_d,
  input  logic            q_rstrobe_d,
  output logic            busy,
  output logic            err
);

  localparam int NIB = 2*LINE_LENGTH + 1;
  localparam int CW  = $clog2(NIB + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] nib_cnt;
  logic [2:0]    gap_cnt;
  logic          last_i;
  logic          settle;

  logic match_stb;
  logic other_stb;
  logic any_stb;
  logic stray;
  logic grant_i;

  assign match_stb = q_i_d ? q_wstrobe_i : (q_write ? q_rstrobe_d : q_wstrobe_d);
  assign other_stb = q_i_d   ? (q_wstrobe_d | q_rstrobe_d) :
                     q_write ? (q_wstrobe_i | q_wstrobe_d) :
                               (q_wstrobe_i | q_rstrobe_d);
  assign any_stb   = q_wstrobe_i | q_wstrobe_d | q_rstrobe_d;
  assign stray     = (state == S_XFER) ? other_stb : any_stb;
  // On a tie the side that was not granted last wins.
  assign grant_i   = i_req & ~(d_req & last_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      nib_cnt <= '0;
      gap_cnt <= '0;
      last_i  <= 1'b1;
      settle  <= 1'b0;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_mem   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (stray) err <= 1'b1;
      case (state)
        S_IDLE: begin
          // The first IDLE cycle after GAP keeps the attributes parked on the controller.
          if (settle) begin
            settle <= 1'b0;
          end else if (i_req | d_req) begin
            state   <= S_ISSUE;
            q_req   <= 1'b1;
            busy    <= 1'b1;
            q_i_d   <= grant_i;
            q_mem   <= grant_i ? i_mem : d_mem;
            q_write <= ~grant_i & d_write;
            q_paddr <= grant_i ? i_addr : d_addr;
          end
        end
        S_ISSUE: begin
          q_req   <= 1'b0;
          nib_cnt <= '0;
          state   <= S_XFER;
        end
        S_XFER: begin
          if (match_stb) begin
            nib_cnt <= nib_cnt + 1'b1;
            if (nib_cnt == CW'(NIB - 1)) begin
              state   <= S_GAP;
              gap_cnt <= 3'(GAP - 1);
              if (q_i_d) i_done <= 1'b1;
              else       d_done <= 1'b1;
            end
          end
        end
        S_GAP: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          last_i <= q_i_d;
          if (gap_cnt == 3'd0) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            settle <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_arb.sv
`default_nettype none
// tb_qspi_arb: directed scoreboard bench for qspi_arb.
// Revision 1.0
module tb_qspi_arb;

  localparam int LINE_LENGTH = 4;
  localparam int PA          = 24;
  localparam int GAP         = 2;
  localparam int AW          = PA - 2;
  localparam int NIB         = 2*LINE_LENGTH + 1;

  typedef struct packed {
    logic          i_d;
    logic          mem;
    logic          wr;
    logic [AW-1:0] addr;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_mem, i_done;
  logic [AW-1:0] i_addr;
  logic          d_req, d_mem, d_write, d_done;
  logic [AW-1:0] d_addr;
  logic          q_req, q_i_d, q_mem, q_write;
  logic [AW-1:0] q_paddr;
  logic          q_wstrobe_i, q_wstrobe_d, q_rstrobe_d;
  logic          busy, err;

  int   n_chk  = 0;
  int   n_pass = 0;
  txn_t sb[$];

  qspi_arb #(.LINE_LENGTH(LINE_LENGTH), .PA(PA), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_mem(i_mem), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_mem(d_mem), .d_write(d_write), .d_addr(d_addr), .d_done(d_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_mem(q_mem), .q_write(q_write), .q_paddr(q_paddr),
    .q_wstrobe_i(q_wstrobe_i), .q_wstrobe_d(q_wstrobe_d), .q_rstrobe_d(q_rstrobe_d),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] kind(input txn_t e);
    return e.i_d ? 3'b100 : (e.wr ? 3'b001 : 3'b010);
  endfunction

  task automatic pulse(input logic [2:0] s);
    {q_wstrobe_i, q_wstrobe_d, q_rstrobe_d} = s;
    step();
    {q_wstrobe_i, q_wstrobe_d, q_rstrobe_d} = 3'b000;
  endtask

  // Waits (bounded) for q_req, then pops and checks the expected transaction.
  task automatic wait_issue(output int cyc, output txn_t e);
    cyc = 0;
    e   = '0;
    while (q_req !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("issue_seen", q_req, 1);
    n_chk = n_chk + 1;
    assert (sb.size() > 0) n_pass = n_pass + 1;
    else $error("FAIL sb_empty: observed issue with %0d queued, expected >0", sb.size());
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("issue_attr", {q_i_d, q_mem, q_write, q_paddr}, e);
    end
  endtask

  // From the ISSUE cycle: drives NIB matching strobes; returns at M+1.
  task automatic run_xfer(input txn_t e);
    logic [2:0] k;
    k = kind(e);
    step();
    chk("q_req_one_cycle", q_req, 0);
    repeat (NIB - 1) pulse(k);
    chk("done_early", {i_done, d_done}, 0);
    pulse(k);
    chk("done_pulse", {i_done, d_done}, e.i_d ? 2'b10 : 2'b01);
    chk("busy_in_gap", busy, 1);
  endtask

  initial begin
    int   cyc;
    txn_t e;
    reset = 1'b0;
    i_req = 0; i_mem = 0; i_addr = '0;
    d_req = 0; d_mem = 0; d_write = 0; d_addr = '0;
    {q_wstrobe_i, q_wstrobe_d, q_rstrobe_d} = 3'b000;
    repeat (3) step();
    chk("rst_outputs", {q_req, q_i_d, q_mem, q_write, q_paddr, i_done, d_done, busy, err}, 0);
    reset = 1'b1;
    repeat (2) step();

    // Both sides held: D, I, D, I.
    i_req = 1; i_mem = 1; i_addr = 22'h00AAA;
    d_req = 1; d_mem = 0; d_write = 0; d_addr = 22'h15555;
    sb.push_back('{1'b0, 1'b0, 1'b0, 22'h15555});
    sb.push_back('{1'b1, 1'b1, 1'b0, 22'h00AAA});
    sb.push_back('{1'b0, 1'b0, 1'b0, 22'h15555});
    sb.push_back('{1'b1, 1'b1, 1'b0, 22'h00AAA});
    for (int k = 0; k < 4; k++) begin
      wait_issue(cyc, e);
      if (k > 0) chk("rr_spacing", 32'(cyc + 1 >= GAP + 3), 1);
      run_xfer(e);
    end
    i_req = 0; d_req = 0;
    repeat (5) step();

    // Single I read, then held i_req re-issues the same line.
    i_req = 1; i_mem = 0; i_addr = 22'h3FFFF;
    sb.push_back('{1'b1, 1'b0, 1'b0, 22'h3FFFF});
    sb.push_back('{1'b1, 1'b0, 1'b0, 22'h3FFFF});
    wait_issue(cyc, e);
    chk("i_issue_latency", cyc, 1);
    run_xfer(e);
    for (int j = 1; j <= GAP; j++) begin
      step();
      if (j == 1) chk("i_done_one_cycle", i_done, 0);
      chk("busy_to_idle", busy, (j < GAP) ? 1 : 0);
    end
    wait_issue(cyc, e);
    chk("held_req_reissue", cyc, 2);
    run_xfer(e);
    i_req = 0;
    repeat (5) step();

    // D writeback completes only on q_rstrobe_d.
    d_req = 1; d_mem = 1; d_write = 1; d_addr = 22'h12345;
    sb.push_back('{1'b0, 1'b1, 1'b1, 22'h12345});
    wait_issue(cyc, e);
    run_xfer(e);
    d_req = 0;
    repeat (5) step();
    chk("err_clean", err, 0);

    // D read with a stray I strobe, then a stray riding on the last matching strobe.
    d_req = 1; d_mem = 0; d_write = 0; d_addr = 22'h00F0F;
    sb.push_back('{1'b0, 1'b0, 1'b0, 22'h00F0F});
    wait_issue(cyc, e);
    step();
    repeat (3) pulse(3'b010);
    pulse(3'b100);
    chk("err_stray_xfer", err, 1);
    repeat (5) pulse(3'b010);
    chk("stray_not_counted", d_done, 0);
    pulse(3'b110);
    chk("match_with_stray", {i_done, d_done}, 2'b01);
    d_req = 0;
    repeat (3) step();
    chk("err_sticky", err, 1);

    // Reset mid-transfer, then a fresh D read.
    i_req = 1; i_mem = 1; i_addr = 22'h2AAAA;
    sb.push_back('{1'b1, 1'b1, 1'b0, 22'h2AAAA});
    wait_issue(cyc, e);
    step();
    repeat (4) pulse(3'b100);
    reset = 1'b0;
    i_req = 0;
    #1;
    chk("rst_async_outputs", {q_req, q_i_d, q_mem, q_write, q_paddr, i_done, d_done, busy, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    pulse(3'b010);
    chk("err_stray_idle", err, 1);
    repeat (3) step();
    d_req = 1; d_mem = 0; d_write = 0; d_addr = 22'h01234;
    sb.push_back('{1'b0, 1'b0, 1'b0, 22'h01234});
    wait_issue(cyc, e);
    chk("post_rst_latency", cyc, 1);
    run_xfer(e);
    d_req = 0;
    repeat (4) step();
    chk("idle_at_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
